// File: rtl/decod_rr_sequencer.sv
// Round-robin sequencer driving a 4-to-16 enabled one-hot decoder.
// One live decoder line per grant, with a forced dead cycle between grants.
module decod_rr_sequencer #(
   parameter int MAX_HOLD = 200,
   parameter int HOLD_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arb_en,
   input  logic [15:0] req,
   input  logic        done,
   output logic [3:0]  dec_sel,
   output logic        dec_en,
   output logic [3:0]  grant_id,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t              state_reg;
   logic [3:0]          ptr_reg;
   logic [HOLD_W-1:0]   hold_cnt_reg;

   logic [15:0]         req_rot;
   logic [3:0]          win_off;
   logic [3:0]          winner;
   logic                any_req;
   logic                owner_req;
   logic                hold_hit;
   logic                grant_exit;

   // req_rot[0] is the requester at ptr, so the lowest set bit is the winner.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_rot
         assign req_rot[gi] = req[4'(ptr_reg + 4'(gi))];
      end
   endgenerate

   always_comb begin
      win_off = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (req_rot[i]) win_off = 4'(i);
      end
   end

   assign winner     = ptr_reg + win_off;
   assign any_req    = |req;
   assign owner_req  = req[grant_id];
   assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
   assign grant_exit = done || !owner_req || hold_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= 4'd0;
         hold_cnt_reg <= '0;
         dec_sel      <= 4'd0;
         dec_en       <= 1'b0;
         grant_id     <= 4'd0;
         busy         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state_reg)
            IDLE, RELEASE: begin
               if (arb_en && any_req) begin
                  dec_sel      <= winner;
                  grant_id     <= winner;
                  dec_en       <= 1'b1;
                  busy         <= 1'b1;
                  hold_cnt_reg <= '0;
                  state_reg    <= GRANT;
               end else begin
                  state_reg    <= IDLE;
               end
            end
            GRANT: begin
               if (grant_exit) begin
                  dec_en    <= 1'b0;
                  busy      <= 1'b0;
                  ptr_reg   <= grant_id + 4'd1;
                  // Expiry only counts as a timeout when nothing else ended the grant.
                  timeout   <= hold_hit && !done && owner_req;
                  state_reg <= RELEASE;
               end else if (hold_cnt_reg != '1) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decod_rr_sequencer.sv
// Self-checking bench for decod_rr_sequencer: directed scenarios then random traffic,
// all compared every cycle against a grant-level behavioural model.
module tb_decod_rr_sequencer;

   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arb_en = 1'b0;
   logic [15:0] req = 16'h0000;
   logic        done = 1'b0;
   logic [3:0]  dec_sel;
   logic        dec_en;
   logic [3:0]  grant_id;
   logic        busy;
   logic        timeout;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: is a grant live, who owns it, how many cycles it has been live so far,
   // where the next scan starts, and whether the last grant ended by expiry.
   bit m_en;
   int m_owner;
   int m_len;
   int m_ptr;
   bit m_to;

   decod_rr_sequencer #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .arb_en   (arb_en),
      .req      (req),
      .done     (done),
      .dec_sel  (dec_sel),
      .dec_en   (dec_en),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input int start, input logic [15:0] r);
      for (int k = 0; k < 16; k++) begin
         if (r[(start + k) % 16]) return (start + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_en = 0; m_owner = 0; m_len = 0; m_ptr = 0; m_to = 0;
   endtask

   task automatic model_edge();
      m_to = 0;
      if (m_en) begin
         if (done || !req[m_owner] || (MAX_HOLD != 0 && m_len == MAX_HOLD)) begin
            m_to  = !(done || !req[m_owner]);
            m_en  = 0;
            m_ptr = (m_owner + 1) % 16;
         end else begin
            m_len++;
         end
      end else if (arb_en && req != 16'h0000) begin
         m_owner = rr_pick(m_ptr, req);
         m_en    = 1;
         m_len   = 1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".dec_en"},   32'(dec_en),   32'(m_en));
      chk({tag, ".busy"},     32'(busy),     32'(m_en));
      chk({tag, ".dec_sel"},  32'(dec_sel),  32'(m_owner));
      chk({tag, ".grant_id"}, 32'(grant_id), 32'(m_owner));
      chk({tag, ".timeout"},  32'(timeout),  32'(m_to));
   endtask

   // Apply inputs (already set), take one clock edge, update model, check 1 ns later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   // Async reset asserted between edges; dec_en must fall without a clock.
   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, ".rst_dec_en"}, 32'(dec_en), 32'd0);
      model_reset();
      check_outputs({tag, ".rst"});
      #1;
      rst_n = 1'b1;
   endtask

   int hi_cnt;
   int to_cnt;

   initial begin
      model_reset();
      #12;
      check_outputs("reset");
      rst_n = 1'b1;

      // T1: reset mid-grant, then re-grant from ptr 0
      arb_en = 1'b1; req = 16'h0020;
      step("t1.grant");
      step("t1.hold");
      chk("t1.mid_en", 32'(dec_en), 32'd1);
      async_reset("t1");
      step("t1.regrant");
      chk("t1.gid5", 32'(grant_id), 32'd5);

      // T2: full rotation with done two cycles after each grant
      async_reset("t2");
      req = 16'hFFFF;
      step("t2.first");
      chk("t2.gid", 32'(grant_id), 32'd0);
      for (int g = 1; g <= 16; g++) begin
         step("t2.hold");
         done = 1'b1;
         step("t2.done");
         done = 1'b0;
         chk("t2.dead", 32'(dec_en), 32'd0);
         step("t2.next");
         chk("t2.gid", 32'(grant_id), 32'(g % 16));
      end

      // T3: ptr=14 after grant 13, wrap to 0 then 2
      async_reset("t3");
      req = 16'h2000;
      step("t3.g13");
      chk("t3.gid13", 32'(grant_id), 32'd13);
      req = 16'h0005;
      step("t3.drop");
      step("t3.g0");
      chk("t3.gid0", 32'(grant_id), 32'd0);
      done = 1'b1;
      step("t3.done");
      done = 1'b0;
      step("t3.g2");
      chk("t3.gid2", 32'(grant_id), 32'd2);

      // T4: hold expiry on sole requester 3
      async_reset("t4");
      req = 16'h0008;
      step("t4.grant");
      hi_cnt = int'(dec_en); to_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         step("t4.hold");
         hi_cnt += int'(dec_en);
         to_cnt += int'(timeout);
      end
      chk("t4.high_cycles", 32'(hi_cnt), 32'd4);
      chk("t4.timeouts", 32'(to_cnt), 32'd1);
      step("t4.regrant");
      chk("t4.regrant_en", 32'(dec_en), 32'd1);
      chk("t4.regrant_id", 32'(grant_id), 32'd3);

      // T5: done coincides with hold expiry
      async_reset("t5");
      req = 16'h0008;
      step("t5.grant");
      for (int c = 0; c < 3; c++) step("t5.hold");
      done = 1'b1;
      step("t5.both");
      done = 1'b0;
      chk("t5.en", 32'(dec_en), 32'd0);
      chk("t5.timeout", 32'(timeout), 32'd0);

      // T6: arb_en gating
      async_reset("t6");
      arb_en = 1'b0; req = 16'h0100;
      for (int c = 0; c < 3; c++) begin
         step("t6.blocked");
         chk("t6.no_grant", 32'(dec_en), 32'd0);
      end
      arb_en = 1'b1;
      step("t6.grant");
      chk("t6.gid8", 32'(grant_id), 32'd8);
      arb_en = 1'b0;
      step("t6.hold1");
      step("t6.hold2");
      chk("t6.held", 32'(dec_en), 32'd1);
      done = 1'b1;
      step("t6.done");
      done = 1'b0;
      chk("t6.released", 32'(dec_en), 32'd0);

      // Random traffic
      async_reset("rnd");
      for (int c = 0; c < 3000; c++) begin
         arb_en = ($urandom_range(0, 9) < 8);
         done   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0)
            req = req ^ (16'h1 << $urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0)
            req = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 299) == 0)
            async_reset("rnd");
         step("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
